dmem_responder: RTL

//  Data-memory responder for the MEM stage of the 5-stage MIPS pipeline. Accepts the
//  mem_ren/mem_wen request issued by the pipeline controller and carried to MEM, serves it

---
 rtl/dmem_responder.sv | 118 +++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// ============================================================================
// Module      : dmem_responder
// Description : MEM-stage data-memory responder. Serves lw/sw from a word RAM
//               after LATENCY wait cycles and stalls the pipeline meanwhile.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        flush,
    output logic [31:0] mem_rdata,
    output logic        mem_done,
    output logic        mem_stall,
    output logic        mem_err,
    output logic [15:0] acc_cnt
);

    localparam int         c_depth     = 1 << ADDR_W;
    localparam logic [3:0] c_wait_init = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic [ADDR_W-1:0]   r_idx;
    logic [31:0]         r_wdata;
    logic                r_is_wr;
    logic [31:0]         r_rdata;
    logic [15:0]         r_acc_cnt;
    logic [31:0]         r_mem [c_depth];

    logic w_req;
    logic w_bad;
    logic w_accept;
    logic w_access;
    logic w_unused_addr;

    assign w_req    = mem_valid & (mem_ren | mem_wen);
    assign w_bad    = (mem_addr[1:0] != 2'b00) | (mem_ren & mem_wen);
    assign w_accept = (r_state == S_IDLE) & w_req & ~w_bad & ~flush;
    assign w_access = (r_state == S_BUSY) & (r_cnt == 4'd0) & ~flush & ~rst;

    // Upper address bits alias onto the RAM index by design.
    assign w_unused_addr = ^mem_addr[31:ADDR_W+2];

    assign mem_stall = (r_state == S_BUSY) | w_accept;
    assign mem_err   = (r_state == S_IDLE) & w_req & w_bad & ~flush;
    assign mem_done  = (r_state == S_DONE);
    assign mem_rdata = r_rdata;
    assign acc_cnt   = r_acc_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_idx     <= '0;
            r_wdata   <= 32'd0;
            r_is_wr   <= 1'b0;
            r_rdata   <= 32'd0;
            r_acc_cnt <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt   <= c_wait_init;
                        r_idx   <= mem_addr[ADDR_W+1:2];
                        r_wdata <= mem_wdata;
                        r_is_wr <= mem_wen;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (flush) begin
                        r_cnt   <= 4'd0;
                        r_state <= S_IDLE;
                    end else if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        if (!r_is_wr) begin
                            r_rdata <= r_mem[r_idx];
                        end
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // The pipeline advances at this edge; the request still on the inputs is stale.
                    r_acc_cnt <= r_acc_cnt + 16'd1;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_access & r_is_wr) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

endmodule

`default_nettype wire
